shreg_univ_burst: RTL and testbench
===================================

Name: shreg_univ_burst

Overview:
- Parametrised N-bit universal shift register, successor to the fixed 4-bit D-flip-flop register.
- Adds parallel load, shift right/left, rotate, hold and clock enable.
- Adds an automatic burst engine that performs a programmed number of shifts and signals completion with a busy/done handshake.
- Used as the general-purpose storage/serialiser block in TP5 and later datapaths.

Parameters:
- N, 8, register width in bits (N >= 2).
- CNT_W, 4, width of the burst shift-count input; max burst = 2^CNT_W - 1.

Ports:
- sclk  input  1  clock, rising edge active.
- srst_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when 0, no register or counter update (FSM stalls).
- mode  input  2  manual op in IDLE: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rot  input  1  1 = rotate (bit shifted out re-enters the other end); 0 = serial fill.
- sin_r  input  1  serial input entering bit N-1 on right shift (rot=0).
- sin_l  input  1  serial input entering bit 0 on left shift (rot=0).
- D  input  N  parallel load data.
- start  input  1  burst request, sampled in IDLE with en=1.
- nshift  input  CNT_W  number of shifts for the burst, captured at start.
- dir  input  1  burst direction, captured at start: 0 right, 1 left.
- Q  output  N  register contents.
- sout_r  output  1  Q[0] (combinational from Q).
- sout_l  output  1  Q[N-1] (combinational from Q).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at end of burst.

Behaviour:
- Reset (srst_n=0, asynchronous): Q=0, busy=0, done=0, remaining count=0, captured dir=0, state=IDLE. Reset mid-burst aborts immediately; no done pulse is generated.
- Shift right: Q <= {fill, Q[N-1:1]}, where fill = rot ? Q[0] : sin_r.
- Shift left: Q <= {Q[N-2:0], fill}, where fill = rot ? Q[N-1] : sin_l.
- All updates occur on rising sclk and only when en=1. If en=0, state, Q and counter hold, and done is deasserted.
- IDLE:
  - If start=1 and en=1: capture nshift and dir, and ignore mode that cycle (start has priority over manual mode).
    - nshift=0: go to DONE.
    - nshift>0: go to RUN.
  - Otherwise apply mode: 00 hold, 01 shift right, 10 shift left, 11 Q<=D.
- RUN:
  - busy=1.
  - Each cycle with en=1: one shift in the captured dir (rot, sin_r and sin_l sampled live); remaining decrements by 1.
  - When a shift is taken with remaining==1, next state is DONE.
  - mode, D, start and nshift are ignored.
  - Latency: a burst of k shifts finishes with k enabled cycles in RUN; done is high on the enabled cycle after the last shift.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state is IDLE; no shift or load occurs in DONE.
  - If en=0 in DONE, the FSM remains in DONE with done=0 until en returns high, then done pulses once.
- Counts above N are legal; with rot=1 the data wraps, e.g. N shifts restores the original Q.
- busy and done are registered outputs derived from state, with no combinational path from inputs.

Test Plan:
- Reset and load: assert srst_n=0 mid-cycle → Q=0x00 immediately. Release, mode=11, D=0xA5, en=1 → Q=0xA5 after 1 clock.
- Manual shifts: from Q=0xA5, rot=0, sin_r=1, mode=01 → Q=0xD2; then mode=10, sin_l=0 → Q=0xA4. sout_r/sout_l track Q[0]/Q[7].
- Rotate burst: Q=0x81, rot=1, dir=1, nshift=3, start pulse → busy high 3 cycles, Q=0x0C, done pulses once; mode=11 applied during RUN has no effect.
- Enable stall and wrap: Q=0x01, rot=1, dir=0, nshift=9, with en low for 2 cycles mid-burst → busy lasts 11 cycles, final Q=0x80, single done pulse.
- Zero count and start while busy: nshift=0 start → done next cycle, busy never high, Q unchanged. A second start asserted during a RUN burst is ignored.
- Reset mid-burst: srst_n low during RUN → Q=0, busy=0, no done. After release the FSM is in IDLE and accepts a new start.

Source files
------------

// File: rtl/shreg_univ_burst.sv
// N-bit universal shift register: manual hold/shift/rotate/load plus an
// automatic burst engine that performs a programmed number of shifts.
module shreg_univ_burst #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             sclk,
  input  logic             srst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [N-1:0]     D,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  input  logic             dir,
  output logic [N-1:0]     Q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_e             state_q, state_d;
  logic [N-1:0]       q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N-1:0]       shr_val, shl_val;

  // Fill bit comes from the opposite end when rotating, else from the serial input.
  assign shr_val = {(rot ? q_q[0]   : sin_r), q_q[N-1:1]};
  assign shl_val = {q_q[N-2:0], (rot ? q_q[N-1] : sin_l)};

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_d   = nshift;
            dir_d   = dir;
            state_d = (nshift == '0) ? S_DONE : S_RUN;
          end else begin
            unique case (mode)
              MODE_HOLD: q_d = q_q;
              MODE_SHR:  q_d = shr_val;
              MODE_SHL:  q_d = shl_val;
              MODE_LOAD: q_d = D;
              default:   q_d = q_q;
            endcase
          end
        end
        S_RUN: begin
          q_d   = dir_q ? shl_val : shr_val;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
        S_DONE: begin
          // Leave only once the pulse has actually been presented with en high.
          if (done_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE);
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[N-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shreg_univ_burst.sv
// Directed bench for shreg_univ_burst (N=8, CNT_W=4) with hand-computed expectations.
module tb_shreg_univ_burst;

  logic       sclk, srst_n, en, rot, sin_r, sin_l, start, dir;
  logic [1:0] mode;
  logic [7:0] D, Q;
  logic [3:0] nshift;
  logic       sout_r, sout_l, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int nb, nd;
  logic [7:0] qd;

  shreg_univ_burst #(.N(8), .CNT_W(4)) dut (
    .sclk(sclk), .srst_n(srst_n), .en(en), .mode(mode), .rot(rot),
    .sin_r(sin_r), .sin_l(sin_l), .D(D), .start(start), .nshift(nshift),
    .dir(dir), .Q(Q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Counts busy/done samples over a fixed window starting just after the start edge.
  task automatic burst(input int en_off_at, input int en_off_len, input int start_at,
                       output int nbusy, output int ndone, output logic [7:0] q_at_done);
    nbusy = 0; ndone = 0; q_at_done = 8'hxx;
    for (int i = 0; i < 30; i++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; q_at_done = Q; end
      en = !(en_off_at >= 0 && i >= en_off_at && i < en_off_at + en_off_len);
      if (i == start_at) begin start = 1'b1; nshift = 4'd5; dir = 1'b1; end
      else start = 1'b0;
      tick();
    end
    en = 1'b1;
  endtask

  initial begin
    srst_n = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0; sin_r = 1'b0; sin_l = 1'b0;
    D = 8'h00; start = 1'b0; nshift = 4'd0; dir = 1'b0;
    #3;
    check("reset_q", 32'(Q), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    tick();
    srst_n = 1'b1;

    // Manual load and shifts
    en = 1'b1; mode = 2'b11; D = 8'hA5;
    tick();
    check("load_q", 32'(Q), 32'hA5);
    check("load_sout_r", 32'(sout_r), 32'h1);
    check("load_sout_l", 32'(sout_l), 32'h1);
    mode = 2'b01; rot = 1'b0; sin_r = 1'b1;
    tick();
    check("shr_q", 32'(Q), 32'hD2);
    check("shr_sout_r", 32'(sout_r), 32'h0);
    mode = 2'b10; sin_l = 1'b0;
    tick();
    check("shl_q", 32'(Q), 32'hA4);
    check("shl_sout_l", 32'(sout_l), 32'h1);
    en = 1'b0; mode = 2'b01;
    tick();
    check("en_hold_q", 32'(Q), 32'hA4);

    // Asynchronous reset in the middle of a cycle
    #3 srst_n = 1'b0;
    #1 check("async_reset_q", 32'(Q), 32'h00);
    tick();
    srst_n = 1'b1; en = 1'b1;

    // Rotate-left burst of 3 with a load request held on mode throughout
    mode = 2'b11; D = 8'h81;
    tick();
    D = 8'hFF; rot = 1'b1; dir = 1'b1; nshift = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("rot_start_q", 32'(Q), 32'h81);
    check("rot_start_busy", 32'(busy), 32'h1);
    burst(-1, 0, -1, nb, nd, qd);
    check("rot_busy_cycles", 32'(nb), 32'd3);
    check("rot_done_pulses", 32'(nd), 32'd1);
    check("rot_q_final", 32'(qd), 32'h0C);

    // Rotate-right burst of 9 with a 2-cycle enable stall
    mode = 2'b11; D = 8'h01;
    tick();
    mode = 2'b00; rot = 1'b1; dir = 1'b0; nshift = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    burst(3, 2, -1, nb, nd, qd);
    check("stall_busy_cycles", 32'(nb), 32'd11);
    check("stall_done_pulses", 32'(nd), 32'd1);
    check("stall_q_final", 32'(qd), 32'h80);

    // Second start during RUN must be ignored
    mode = 2'b11; D = 8'h0F;
    tick();
    mode = 2'b00; rot = 1'b0; sin_r = 1'b0; dir = 1'b0; nshift = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    burst(-1, 0, 0, nb, nd, qd);
    check("restart_busy_cycles", 32'(nb), 32'd2);
    check("restart_done_pulses", 32'(nd), 32'd1);
    check("restart_q_final", 32'(qd), 32'h03);
    check("restart_q_idle", 32'(Q), 32'h03);

    // Zero-count burst: done next cycle, never busy, Q untouched
    nshift = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    check("zero_q", 32'(Q), 32'h03);
    tick();
    check("zero_done_clear", 32'(done), 32'h0);
    check("zero_busy_after", 32'(busy), 32'h0);

    // Reset in the middle of a burst aborts without a done pulse
    nshift = 4'd7; dir = 1'b1; rot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort_busy_before", 32'(busy), 32'h1);
    #2 srst_n = 1'b0;
    #1;
    check("abort_q", 32'(Q), 32'h00);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    tick();
    check("abort_done_held", 32'(done), 32'h0);
    srst_n = 1'b1;

    // New burst accepted after reset release
    mode = 2'b11; D = 8'h3C;
    tick();
    mode = 2'b00; rot = 1'b0; sin_l = 1'b1; dir = 1'b1; nshift = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    burst(-1, 0, -1, nb, nd, qd);
    check("post_busy_cycles", 32'(nb), 32'd1);
    check("post_done_pulses", 32'(nd), 32'd1);
    check("post_q_final", 32'(qd), 32'h79);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
